// File: rtl/controle_pilha_rpn.sv
// rtl/controle_pilha_rpn.sv - RPN operand stack controller sequencing an external ALU
// Pushes operands on ENTER, hands the top two to the ALU on EXEC and writes the result back.
module controle_pilha_rpn #(
    parameter int LARGURA      = 8,
    parameter int PROFUNDIDADE = 4,
    parameter int TIMEOUT      = 15
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               enter_i,
    input  logic               exec_i,
    input  logic [LARGURA-1:0] data_in_i,
    input  logic [2:0]         opcode_in_i,
    input  logic [LARGURA-1:0] alu_result_i,
    input  logic               alu_ovf_i,
    input  logic               alu_ready_i,
    output logic [LARGURA-1:0] alu_a_o,
    output logic [LARGURA-1:0] alu_b_o,
    output logic [2:0]         alu_op_o,
    output logic               alu_go_o,
    output logic [LARGURA-1:0] top_o,
    output logic [2:0]         depth_o,
    output logic [1:0]         passo_o,
    output logic               busy_o,
    output logic               erro_o
);

    localparam int            AW        = (PROFUNDIDADE > 1) ? $clog2(PROFUNDIDADE) : 1;
    localparam int            CW        = $clog2(TIMEOUT + 1);
    localparam logic [2:0]    DEPTH_MAX = 3'(PROFUNDIDADE);
    localparam logic [CW-1:0] CNT_LAST  = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'b00,
        S_ISSUE     = 2'b01,
        S_WAIT      = 2'b10,
        S_WRITEBACK = 2'b11
    } passo_t;

    passo_t             passo_q;
    logic [LARGURA-1:0] stack_q [PROFUNDIDADE];
    logic [2:0]         depth_q;
    logic               erro_q;
    logic               alu_go_q;
    logic               enter_prev_q;
    logic               exec_prev_q;
    logic [LARGURA-1:0] alu_a_q;
    logic [LARGURA-1:0] alu_b_q;
    logic [2:0]         alu_op_q;
    logic [LARGURA-1:0] res_q;
    logic               ovf_q;
    logic [CW-1:0]      cnt_q;

    logic               enter_rise_d;
    logic               exec_rise_d;
    logic [AW-1:0]      idx_top_d;
    logic [AW-1:0]      idx_sec_d;
    logic [AW-1:0]      idx_push_d;

    always_comb begin
        enter_rise_d = enter_i & ~enter_prev_q;
        exec_rise_d  = exec_i & ~exec_prev_q;
        idx_top_d    = AW'(depth_q - 3'd1);
        idx_sec_d    = AW'(depth_q - 3'd2);
        idx_push_d   = AW'(depth_q);
    end

    // Edge registers track the inputs in every state, so edges seen while busy are simply lost.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            passo_q      <= S_IDLE;
            depth_q      <= '0;
            erro_q       <= 1'b0;
            alu_go_q     <= 1'b0;
            enter_prev_q <= 1'b0;
            exec_prev_q  <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            res_q        <= '0;
            ovf_q        <= 1'b0;
            cnt_q        <= '0;
            for (int i = 0; i < PROFUNDIDADE; i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            enter_prev_q <= enter_i;
            exec_prev_q  <= exec_i;
            alu_go_q     <= 1'b0;

            case (passo_q)
                S_IDLE: begin
                    if (enter_rise_d) begin
                        if (depth_q < DEPTH_MAX) begin
                            stack_q[idx_push_d] <= data_in_i;
                            depth_q             <= depth_q + 3'd1;
                            erro_q              <= 1'b0;
                        end else begin
                            erro_q <= 1'b1;
                        end
                    end else if (exec_rise_d) begin
                        if (depth_q < 3'd2) begin
                            erro_q <= 1'b1;
                        end else begin
                            alu_a_q  <= stack_q[idx_sec_d];
                            alu_b_q  <= stack_q[idx_top_d];
                            alu_op_q <= opcode_in_i;
                            alu_go_q <= 1'b1;
                            passo_q  <= S_ISSUE;
                        end
                    end
                end

                S_ISSUE: begin
                    cnt_q   <= '0;
                    passo_q <= S_WAIT;
                end

                S_WAIT: begin
                    if (alu_ready_i) begin
                        res_q   <= alu_result_i;
                        ovf_q   <= alu_ovf_i;
                        passo_q <= S_WRITEBACK;
                    end else if (cnt_q == CNT_LAST) begin
                        erro_q  <= 1'b1;
                        passo_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                S_WRITEBACK: begin
                    // Result replaces the second operand; the old top slot becomes dead above depth.
                    stack_q[idx_sec_d] <= res_q;
                    depth_q            <= depth_q - 3'd1;
                    if (ovf_q) begin
                        erro_q <= 1'b1;
                    end
                    passo_q <= S_IDLE;
                end

                default: passo_q <= S_IDLE;
            endcase
        end
    end

    assign alu_a_o  = alu_a_q;
    assign alu_b_o  = alu_b_q;
    assign alu_op_o = alu_op_q;
    assign alu_go_o = alu_go_q;
    assign depth_o  = depth_q;
    assign passo_o  = passo_q;
    assign busy_o   = (passo_q != S_IDLE);
    assign erro_o   = erro_q;
    assign top_o    = (depth_q == 3'd0) ? '0 : stack_q[idx_top_d];

endmodule

// File: doc/controle_pilha_rpn.md
CONTROLE_PILHA_RPN -- requirements
Module: controle_pilha_rpn

Interface
REQ-001 Parameter LARGURA, 8, data/operand width in bits.
REQ-002 Parameter PROFUNDIDADE, 4, operand stack entries.
REQ-003 Parameter TIMEOUT, 15, max cycles waited for ALU_READY.
REQ-004 CLOCK  in  1  single clock; all state changes on rising edge.
REQ-005 RESET  in  1  asynchronous, active-low reset.
REQ-006 ENTER  in  1  level; rising edge requests push of DATA_IN.
REQ-007 EXEC  in  1  level; rising edge requests an operation.
REQ-008 DATA_IN  in  LARGURA  operand to push.
REQ-009 OPCODE_IN  in  3  ALU operation code, sampled on accepted EXEC.
REQ-010 ALU_RESULT  in  LARGURA  ALU result.
REQ-011 ALU_OVF  in  1  ALU overflow/carry flag, valid with ALU_READY.
REQ-012 ALU_READY  in  1  ALU result valid.
REQ-013 ALU_A, ALU_B  out  LARGURA each  latched operands (A = second, B = top).
REQ-014 ALU_OP  out  3  latched opcode.
REQ-015 ALU_GO  out  1  one-cycle start strobe.
REQ-016 TOP  out  LARGURA  top-of-stack value; 0 when stack empty.
REQ-017 DEPTH  out  3  stack occupancy, 0..PROFUNDIDADE.
REQ-018 PASSO  out  2  FSM state code.
REQ-019 BUSY  out  1  high when PASSO != IDLE.
REQ-020 ERRO  out  1  sticky error flag.

Function
REQ-021 FSM states and PASSO codes SHALL be: IDLE=00, ISSUE=01, WAIT=10, WRITEBACK=11.
REQ-022 ENTER/EXEC edges SHALL be detected via registered previous value; detection occurs one cycle after the input rises.
REQ-023 Edges arriving outside IDLE SHALL be discarded (not queued).
REQ-024 ENTER edge in IDLE with DEPTH<PROFUNDIDADE: push DATA_IN, DEPTH+1, clear ERRO, next cycle; state stays IDLE.
REQ-025 ENTER edge in IDLE with DEPTH=PROFUNDIDADE: stack unchanged, ERRO=1.
REQ-026 EXEC edge in IDLE with DEPTH<2: stack unchanged, ERRO=1, stay IDLE.
REQ-027 EXEC edge in IDLE with DEPTH>=2: latch ALU_A=entry[DEPTH-2], ALU_B=entry[DEPTH-1], ALU_OP=OPCODE_IN; go to ISSUE.
REQ-028 Simultaneous ENTER and EXEC edges in IDLE: ENTER processed, EXEC discarded.
REQ-029 ISSUE: ALU_GO=1 for exactly this one cycle; next state WAIT; wait counter cleared.
REQ-030 WAIT: ALU_READY=1 captures ALU_RESULT/ALU_OVF, next state WRITEBACK; ALU_READY in any other state SHALL be ignored.
REQ-031 WAIT: after TIMEOUT cycles without ALU_READY, ERRO=1, stack unchanged, return to IDLE.
REQ-032 WRITEBACK: pop two entries, push captured result (DEPTH-1, TOP=result); ERRO=1 if captured ALU_OVF=1 (result still pushed); next state IDLE.
REQ-033 ALU_A/ALU_B/ALU_OP SHALL hold until the next accepted EXEC.
REQ-034 ERRO SHALL clear only on reset or accepted ENTER push.
REQ-035 Entries above DEPTH SHALL not affect TOP; TOP updates the cycle DEPTH changes.

Reset
REQ-036 RESET=0 SHALL immediately force: state IDLE, PASSO=00, BUSY=0, ALU_GO=0, DEPTH=0, TOP=0, ERRO=0, ALU_A=ALU_B=0, ALU_OP=0, all stack entries 0, edge registers 0, wait counter 0.
REQ-037 Reset asserted mid-operation (ISSUE/WAIT/WRITEBACK) SHALL abort with no writeback.
REQ-038 An ENTER/EXEC input already high at reset release SHALL count as a rising edge in the first clocked cycle.

Verification
REQ-039 Push 8'h05, 8'h03, EXEC op=000, ALU_READY 2 cycles after ALU_GO with 8'h08 -> ALU_A=05, ALU_B=03, ALU_GO one cycle, DEPTH=1, TOP=08, ERRO=0.
REQ-040 Five pushes 01..05 -> DEPTH=4 after four, fifth sets ERRO=1, TOP=04; next push rejected, ERRO stays 1 until a push is accepted.
REQ-041 DEPTH=1, EXEC -> ERRO=1, PASSO stays 00, ALU_GO never asserted.
REQ-042 EXEC with ALU_READY held 0 -> after 15 WAIT cycles ERRO=1, PASSO=00, DEPTH and TOP unchanged.
REQ-043 ENTER and EXEC rise same cycle at DEPTH=2 -> push only, DEPTH=3, no ALU_GO; ENTER pulse during WAIT ignored.
REQ-044 RESET low during WAIT -> all outputs at reset values within same cycle; ALU_READY after release has no effect.
